// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file and its pending scoreboard.
package regfile_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned AddrW = 3;

    typedef logic [AddrW-1:0] reg_idx_t;
    typedef logic [DataW-1:0] data_word_t;

endpackage

// File: rtl/regfile_pending_sb.sv
// Per-register pending scoreboard: claim sets, write clears, flush clears all,
// plus a registered popcount of the pending vector.
module regfile_pending_sb
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = AddrW,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic                    claim_en_i,
    input  logic [ADDR_W-1:0]       claim_addr_i,
    input  logic                    flush_i,
    output logic [(2**ADDR_W)-1:0]  pending_o,
    output logic [ADDR_W:0]         pending_cnt_o
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [NREGS-1:0] pending_d, pending_q;
    logic [ADDR_W:0]  cnt_d, cnt_q;

    // Priority, lowest to highest: write clear, claim set, flush, r0 mask.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_i) begin
            pending_d[wr_addr_i] = 1'b0;
        end
        if (claim_en_i) begin
            pending_d[claim_addr_i] = 1'b1;
        end
        if (flush_i) begin
            pending_d = '0;
        end
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end
    end

    // Count tracks the current pending vector, so it trails it by one edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pending_q[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o     = pending_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with 1 write / 2 async read / 1 debug port, same-cycle bypass
// and a pending scoreboard for multi-cycle producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DataW,
    parameter int unsigned ADDR_W   = AddrW,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              rd_busy_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_2,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pending;
    logic              wr_live;

    // A write to r0 is dropped entirely when r0 is hardwired.
    assign wr_live = wr_en && !(ZERO_REG && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    regfile_pending_sb #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_pending_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .claim_en_i   (claim_en),
        .claim_addr_i (claim_addr),
        .flush_i      (flush),
        .pending_o    (pending),
        .pending_cnt_o(pending_cnt)
    );

    always_comb begin
        rd_data_1 = regs_q[rd_addr_1];
        if (BYPASS && wr_en && (wr_addr == rd_addr_1)) begin
            rd_data_1 = wr_data;
        end
        if (ZERO_REG && (rd_addr_1 == '0)) begin
            rd_data_1 = '0;
        end
    end

    always_comb begin
        rd_data_2 = regs_q[rd_addr_2];
        if (BYPASS && wr_en && (wr_addr == rd_addr_2)) begin
            rd_data_2 = wr_data;
        end
        if (ZERO_REG && (rd_addr_2 == '0)) begin
            rd_data_2 = '0;
        end
    end

    // An in-flight write resolves the hazard in the same cycle.
    assign rd_busy_1 = pending[rd_addr_1] && !(wr_en && (wr_addr == rd_addr_1))
                       && !(ZERO_REG && (rd_addr_1 == '0));
    assign rd_busy_2 = pending[rd_addr_2] && !(wr_en && (wr_addr == rd_addr_2))
                       && !(ZERO_REG && (rd_addr_2 == '0));

    assign dbg_data = regs_q[dbg_addr];

endmodule
